// File: rtl/pbp_train_sched_if.sv
// pbp_train_sched_if: resolved-branch event stream and perceptron table port bundle
interface pbp_train_sched_if #(
   parameter int w_bits   = 8,
   parameter int hist_len = 12,
   parameter int b_sets   = 5
);
   logic                           ev_valid;
   logic                           ev_ready;
   logic [b_sets-1:0]              ev_index;
   logic                           ev_taken;
   logic                           ev_pred;
   logic [w_bits-1:0]              ev_y;
   logic [hist_len-1:0]            ev_hist;
   logic [b_sets-1:0]              pt_rd_index;
   logic [(hist_len+1)*w_bits-1:0] pt_rd_data;
   logic                           pt_wr_en;
   logic [b_sets-1:0]              pt_wr_index;
   logic [(hist_len+1)*w_bits-1:0] pt_wr_data;

   modport slave (
      input  ev_valid, ev_index, ev_taken, ev_pred, ev_y, ev_hist, pt_rd_data,
      output ev_ready, pt_rd_index, pt_wr_en, pt_wr_index, pt_wr_data
   );

   modport master (
      output ev_valid, ev_index, ev_taken, ev_pred, ev_y, ev_hist, pt_rd_data,
      input  ev_ready, pt_rd_index, pt_wr_en, pt_wr_index, pt_wr_data
   );
endinterface

// File: rtl/pbp_train_sched.sv
// pbp_train_sched: clears the perceptron table after reset, then filters, queues and applies saturating training updates
module pbp_train_sched #(
   parameter int w_bits   = 8,
   parameter int hist_len = 12,
   parameter int b_sets   = 5,
   parameter int q_depth  = 4,
   parameter int theta    = 37
) (
   input  logic             clk,
   input  logic             rst_n,
   pbp_train_sched_if.slave bus,
   output logic             init_busy_o,
   output logic [15:0]      train_cnt_o
);
   localparam int aw = $clog2(q_depth);
   localparam int rw = (hist_len + 1) * w_bits;
   localparam int ew = b_sets + hist_len + 1;
   localparam logic [w_bits:0]   theta_c = (w_bits + 1)'(theta);
   localparam logic [w_bits-1:0] w_max   = {1'b0, {(w_bits - 1){1'b1}}};
   localparam logic [w_bits-1:0] w_min   = {1'b1, {(w_bits - 1){1'b0}}};

   typedef enum logic [1:0] {RST, INIT, IDLE, WR} state_t;

   state_t              state_q, state_d;
   logic [ew-1:0]       fifo_q [q_depth];
   logic [aw-1:0]       wp_q, rp_q;
   logic [aw:0]         cnt_q;
   logic [b_sets-1:0]   init_q, lat_idx_q;
   logic                lat_taken_q;
   logic [hist_len-1:0] lat_hist_q;
   logic [rw-1:0]       lat_row_q, upd_row;
   logic [15:0]         train_cnt_q;
   logic [hist_len:0]   up_v;
   logic [w_bits:0]     y_ext, abs_y;
   logic                push, pop, empty, full;

   assign empty = cnt_q == '0;
   assign full  = cnt_q == (aw + 1)'(q_depth);
   assign bus.ev_ready = (state_q == IDLE || state_q == WR) && !full;
   assign y_ext = {bus.ev_y[w_bits-1], bus.ev_y};
   assign abs_y = y_ext[w_bits] ? -y_ext : y_ext;
   assign push  = bus.ev_valid && bus.ev_ready && (bus.ev_pred != bus.ev_taken || abs_y <= theta_c);
   assign pop   = state_q == WR;
   assign bus.pt_rd_index = fifo_q[rp_q][ew-1 -: b_sets];
   assign train_cnt_o = train_cnt_q;

   // Bias moves toward the outcome; each history weight moves toward agreement with its history bit
   assign up_v = {lat_taken_q, ~(lat_hist_q ^ {hist_len{lat_taken_q}})};

   for (genvar i = 0; i <= hist_len; i++) begin : g_upd
      logic [w_bits-1:0] w;
      assign w = lat_row_q[i*w_bits +: w_bits];
      assign upd_row[i*w_bits +: w_bits] = up_v[i] ? (w == w_max ? w : w + 1'b1)
                                                   : (w == w_min ? w : w - 1'b1);
   end

   // State, queue pointers, clear counter and commit counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RST;
         wp_q        <= '0;
         rp_q        <= '0;
         cnt_q       <= '0;
         init_q      <= '0;
         train_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) init_q <= init_q + 1'b1;
         if (push) wp_q <= wp_q + 1'b1;
         if (pop) rp_q <= rp_q + 1'b1;
         if (pop) train_cnt_q <= train_cnt_q + 16'd1;
         cnt_q <= cnt_q + (aw + 1)'(push) - (aw + 1)'(pop);
      end
   end

   // Queue storage and the head snapshot taken in IDLE so WR writes a consistent update
   always_ff @(posedge clk) begin
      if (push) fifo_q[wp_q] <= {bus.ev_index, bus.ev_taken, bus.ev_hist};
      if (state_q == IDLE && !empty) begin
         lat_idx_q   <= fifo_q[rp_q][ew-1 -: b_sets];
         lat_taken_q <= fifo_q[rp_q][hist_len];
         lat_hist_q  <= fifo_q[rp_q][hist_len-1:0];
         lat_row_q   <= bus.pt_rd_data;
      end
   end

   // Next state and table write port: zero rows during the clear, trained row in WR
   always_comb begin
      state_d         = state_q;
      bus.pt_wr_en    = 1'b0;
      bus.pt_wr_index = lat_idx_q;
      bus.pt_wr_data  = upd_row;
      init_busy_o     = 1'b0;
      case (state_q)
         RST: begin
            init_busy_o = 1'b1;
            state_d     = INIT;
         end
         INIT: begin
            init_busy_o     = 1'b1;
            bus.pt_wr_en    = 1'b1;
            bus.pt_wr_index = init_q;
            bus.pt_wr_data  = '0;
            state_d         = init_q == '1 ? IDLE : INIT;
         end
         IDLE: state_d = empty ? IDLE : WR;
         WR: begin
            bus.pt_wr_en = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = RST;
      endcase
   end
endmodule
